// File: rtl/ce_window_mc_if.sv
// Avalon-ST style sample stream carrying NCH packed complex channels plus frame length.
interface ce_window_mc_if #(
    parameter int wDataInOut = 24,
    parameter int NCH        = 2,
    parameter int wPts       = 12
);
    logic                        valid;
    logic                        ready;
    logic                        sop;
    logic                        eop;
    logic [1:0]                  error;
    logic [NCH*wDataInOut-1:0]   data_real;
    logic [NCH*wDataInOut-1:0]   data_imag;
    logic [wPts-1:0]             fftpts;

    modport master (
        output valid, sop, eop, error, data_real, data_imag, fftpts,
        input  ready
    );

    modport slave (
        input  valid, sop, eop, error, data_real, data_imag, fftpts,
        output ready
    );
endinterface

// File: rtl/ce_window_mc.sv
// Multi-channel DCT-domain window: unity gain for the first keep bins, linear taper, then zero.
// Define CE_WINDOW_ERRCNT_EN to build the saturating framing-error counter on err_cnt.
module ce_window_mc #(
    parameter int wDataInOut = 24,
    parameter int NCH        = 2,
    parameter int wGain      = 16,
    parameter int wPts       = 12
) (
    input  logic            clk,
    input  logic            rst_n_sync,
    ce_window_mc_if.slave   sink,
    ce_window_mc_if.master  source,
    input  logic [wPts-1:0] cfg_keep,
    input  logic [3:0]      cfg_taper_log2,
    output logic [15:0]     err_cnt
);
    localparam int wBus  = NCH * wDataInOut;
    localparam int wWide = ((wPts > wGain) ? wPts : wGain) + wGain + 1;
    localparam int wProd = wDataInOut + wGain + 1;
    localparam logic [wGain-1:0]        UNITY = {1'b1, {(wGain-1){1'b0}}};
    localparam logic signed [wProd-1:0] RND   = wProd'(1) << (wGain-2);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t          state, state_nxt;
    logic [wPts-1:0] k, k_nxt, n_reg, keep_reg;
    logic [3:0]      tlog_reg;
    logic            en, acc, take, last, frame_err;
    logic [wPts-1:0] eff_k, eff_n, eff_keep;
    logic [3:0]      eff_tlog;
    logic [wWide-1:0] k_w, keep_w, end_w, dist_w;
    logic [wGain-1:0] gain;

    logic             s1_valid, s1_sop, s1_eop;
    logic [1:0]       s1_err;
    logic [wPts-1:0]  s1_n;
    logic [wGain-1:0] s1_gain;
    logic [wBus-1:0]  s1_real, s1_imag, y_real, y_imag;

    assign en         = !source.valid || source.ready;
    assign sink.ready = en;
    assign acc        = sink.valid && en;

    // A sop beat uses the config presented with it, not the previous frame's.
    assign eff_k    = sink.sop ? '0 : k;
    assign eff_n    = sink.sop ? sink.fftpts : n_reg;
    assign eff_keep = sink.sop ? cfg_keep : keep_reg;
    assign eff_tlog = sink.sop ? cfg_taper_log2 : tlog_reg;

    assign last      = (eff_k == eff_n - wPts'(1));
    assign frame_err = (sink.sop && state == FRAME) || (sink.eop != last);
    assign take      = acc && (sink.sop || state == FRAME);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        k_w    = wWide'(eff_k);
        keep_w = wWide'(eff_keep);
        end_w  = keep_w + (wWide'(1) << eff_tlog);
        dist_w = end_w - k_w;
        gain   = '0;
        if (k_w < keep_w)
            gain = UNITY;
        else if (k_w < end_w)
            gain = wGain'((dist_w << (wGain-1)) >> eff_tlog);
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        if (take) begin
            if (sink.eop || last) begin
                state_nxt = IDLE;
                k_nxt     = '0;
            end else begin
                state_nxt = FRAME;
                k_nxt     = eff_k + wPts'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            n_reg    <= '0;
            keep_reg <= '0;
            tlog_reg <= '0;
        end else if (take && sink.sop) begin
            n_reg    <= sink.fftpts;
            keep_reg <= cfg_keep;
            tlog_reg <= cfg_taper_log2;
        end
    end

    // NOTE: datapath registers are reset too, so a mid-frame reset leaves nothing stale to leak out.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_err   <= '0;
            s1_n     <= '0;
            s1_gain  <= '0;
            s1_real  <= '0;
            s1_imag  <= '0;
        end else if (en) begin
            s1_valid <= take;
            if (take) begin
                s1_sop  <= sink.sop;
                s1_eop  <= sink.eop;
                s1_err  <= {sink.error[1] | sink.error[0], frame_err};
                s1_n    <= eff_n;
                s1_gain <= gain;
                s1_real <= sink.data_real;
                s1_imag <= sink.data_imag;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [wProd-1:0] p_re, p_im;
        assign p_re = wProd'($signed(s1_real[c*wDataInOut +: wDataInOut])) * wProd'($signed({1'b0, s1_gain}));
        assign p_im = wProd'($signed(s1_imag[c*wDataInOut +: wDataInOut])) * wProd'($signed({1'b0, s1_gain}));
        // Gain never exceeds unity, so the rounded result always fits the sample width.
        assign y_real[c*wDataInOut +: wDataInOut] = wDataInOut'((p_re + RND) >>> (wGain-1));
        assign y_imag[c*wDataInOut +: wDataInOut] = wDataInOut'((p_im + RND) >>> (wGain-1));
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            source.valid     <= 1'b0;
            source.sop       <= 1'b0;
            source.eop       <= 1'b0;
            source.error     <= '0;
            source.data_real <= '0;
            source.data_imag <= '0;
            source.fftpts    <= '0;
        end else if (en) begin
            source.valid <= s1_valid;
            if (s1_valid) begin
                source.sop       <= s1_sop;
                source.eop       <= s1_eop;
                source.error     <= s1_err;
                source.data_real <= y_real;
                source.data_imag <= y_imag;
                if (s1_sop)
                    source.fftpts <= s1_n;
            end
        end
    end

`ifdef CE_WINDOW_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync)
            err_cnt <= '0;
        else if (take && frame_err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif
endmodule
